// File: rtl/mux_arb_pkg.sv
// Shared types for the N-channel arbitrated mux.
// Mode encoding and counter width.
package mux_arb_pkg;

  typedef enum logic [1:0] {
    MODE_SEL  = 2'd0,
    MODE_PRIO = 2'd1,
    MODE_RR   = 2'd2,
    MODE_RSVD = 2'd3
  } mux_mode_e;

  localparam int CNT_W = 16;

endpackage

// File: rtl/mux_arb_nch_rr.sv
// Rotating-priority arbiter: first request at or
// after ptr, searching upward modulo N.
module rr_arbiter_nch #(
  parameter  int N    = 4,
  localparam int SELW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic [N-1:0]    gnt
);

  int          idx;
  logic [SELW-1:0] pos;
  logic        found;

  // scan N slots from ptr, wrapping, keep first hit
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    pos   = '0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      pos = idx[SELW-1:0];
      if (!found && req[pos]) begin
        gnt[pos] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_arb_nch.sv
// N-channel W-bit arbitrated mux with a registered,
// single-entry valid/ready output stage.
module mux_arb_nch
  import mux_arb_pkg::*;
#(
  parameter  int N    = 4,
  parameter  int W    = 8,
  localparam int SELW = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic [SELW-1:0]  sel,
  input  logic [N-1:0]     in_valid,
  input  logic [N*W-1:0]   in_data,
  output logic [N-1:0]     in_ready,
  output logic             out_valid,
  output logic [W-1:0]     out_data,
  output logic [SELW-1:0]  out_chan,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_cnt
);

  mux_mode_e       mode_e;
  logic            is_rr;
  logic            is_prio;
  logic            is_sel;
  logic            load;
  logic            xfer_in;
  logic            xfer_out;
  logic [SELW-1:0] rr_ptr;
  logic [N-1:0]    gnt_rr;
  logic [N-1:0]    gnt_sel;
  logic [N-1:0]    gnt_prio;
  logic [N-1:0]    grant;
  logic            prio_hit;
  logic [SELW-1:0] win;
  logic [W-1:0]    win_data;

  assign mode_e  = mux_mode_e'(mode);
  assign is_rr   = (mode_e == MODE_RR);
  assign is_prio = (mode_e == MODE_PRIO);
  assign is_sel  = !is_rr && !is_prio;

  assign load     = !out_valid || out_ready;
  assign xfer_out = out_valid && out_ready;

  rr_arbiter_nch #(.N(N)) u_rr (
    .req (in_valid),
    .ptr (rr_ptr),
    .gnt (gnt_rr)
  );

  // external select; out-of-range index grants nothing
  always_comb begin
    gnt_sel = '0;
    if (int'(sel) < N && in_valid[sel])
      gnt_sel[sel] = 1'b1;
  end

  // fixed priority, lowest index wins
  always_comb begin
    gnt_prio = '0;
    prio_hit = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!prio_hit && in_valid[i]) begin
        gnt_prio[i] = 1'b1;
        prio_hit    = 1'b1;
      end
    end
  end

  // pick the grant vector for the active mode
  always_comb begin
    grant = '0;
    unique case (1'b1)
      is_rr:   grant = gnt_rr;
      is_prio: grant = gnt_prio;
      is_sel:  grant = gnt_sel;
      default: grant = '0;
    endcase
  end

  assign in_ready = (load && !rst) ? grant : '0;
  assign xfer_in  = |(in_valid & in_ready);

  // encode winner index and fetch its data word
  always_comb begin
    win      = '0;
    win_data = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) begin
        win      = SELW'(i);
        win_data = in_data[i*W +: W];
      end
    end
  end

  // output register, transfer counter, rr pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      out_cnt   <= '0;
      rr_ptr    <= '0;
    end else begin
      if (xfer_out)
        out_cnt <= out_cnt + 1'b1;
      if (xfer_in) begin
        out_valid <= 1'b1;
        out_data  <= win_data;
        out_chan  <= win;
        if (is_rr)
          rr_ptr <= (win == SELW'(N-1)) ? '0 : win + 1'b1;
      end else if (xfer_out) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_arb_nch.sv
// Randomised and directed bench for mux_arb_nch
// against a transaction-level reference model.
module tb_mux_arb_nch;

  localparam int N = 4;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   mode;
  logic [1:0]   sel;
  logic [3:0]   in_valid;
  logic [31:0]  in_data;
  logic [3:0]   in_ready;
  logic         out_valid;
  logic [7:0]   out_data;
  logic [1:0]   out_chan;
  logic         out_ready;
  logic [15:0]  out_cnt;

  int n_vec = 0;
  int n_err = 0;

  int e_valid;
  int e_data;
  int e_chan;
  int e_cnt;
  int e_ptr;

  mux_arb_nch #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_chan  (out_chan),
    .out_ready (out_ready),
    .out_cnt   (out_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    e_valid = 0; e_data = 0; e_chan = 0;
    e_cnt = 0;   e_ptr = 0;
  endfunction

  // winning channel by the mode's rule, -1 if none
  function automatic int pick(input int m, input int s,
                              input logic [3:0] v);
    int c;
    if (m == 2) begin
      for (int k = 0; k < N; k++) begin
        c = (e_ptr + k) % N;
        if (v[c]) return c;
      end
      return -1;
    end
    if (m == 1) begin
      for (int k = 0; k < N; k++)
        if (v[k]) return k;
      return -1;
    end
    c = s % 4;
    if (c < N && v[c]) return c;
    return -1;
  endfunction

  task automatic check_out(input string pfx);
    chk({pfx, ".out_valid"}, int'(out_valid), e_valid);
    chk({pfx, ".out_data"},  int'(out_data),  e_data);
    chk({pfx, ".out_chan"},  int'(out_chan),  e_chan);
    chk({pfx, ".out_cnt"},   int'(out_cnt),   e_cnt);
  endtask

  // one cycle: drive, check outputs + ready, advance model
  task automatic step(input int m, input int s,
                      input logic [3:0] v,
                      input logic [31:0] d,
                      input logic r,
                      output logic [3:0] rdy_exp);
    int w;
    int ld;
    @(negedge clk);
    mode = m[1:0]; sel = s[1:0];
    in_valid = v; in_data = d; out_ready = r;
    #1;
    w  = pick(m, s, v);
    ld = (e_valid == 0) || r;
    rdy_exp = (ld != 0 && w >= 0) ? 4'(1 << w) : 4'd0;
    check_out("cyc");
    chk("in_ready", int'(in_ready), int'(rdy_exp));
    @(posedge clk);
    if (e_valid != 0 && r) e_cnt = (e_cnt + 1) % 65536;
    if (rdy_exp != 0) begin
      e_valid = 1;
      e_data  = int'(d[w*8 +: 8]);
      e_chan  = w;
      if (m == 2) e_ptr = (w + 1) % N;
    end else if (e_valid != 0 && r) begin
      e_valid = 0;
    end
  endtask

  logic [3:0]  rq;
  logic [31:0] dat;
  logic [3:0]  vv;

  initial begin
    rst = 1'b1; mode = 2'd0; sel = 2'd0;
    in_valid = 4'd0; in_data = 32'd0; out_ready = 1'b0;
    model_reset();
    #12;
    check_out("rst");
    chk("rst.in_ready", int'(in_ready), 0);
    @(negedge clk);
    rst = 1'b0;

    // build up out_cnt=3 with 0x5A held, then async reset
    for (int i = 0; i < 4; i++)
      step(0, 0, 4'b0001, 32'h0000005A, 1'b1, rq);
    #1;
    check_out("pre_rst");
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_out("async_rst");
    chk("async_rst.in_ready", int'(in_ready), 0);
    in_valid = 4'd0;
    #1;
    rst = 1'b0;
    step(2, 0, 4'b1111, 32'h44332211, 1'b1, rq);
    chk("rr_first", int'(rq), 1);

    // SEL mode, sel=2, then sel=5 truncated to 1
    for (int i = 0; i < 3; i++)
      step(0, 2, 4'b1111, 32'h44332211, 1'b1, rq);
    for (int i = 0; i < 3; i++)
      step(0, 5, 4'b1111, 32'h44332211, 1'b1, rq);
    step(3, 3, 4'b0111, 32'h44332211, 1'b1, rq);

    // PRIO: channel 1 beats channel 3 every cycle
    for (int i = 0; i < 4; i++)
      step(1, 0, 4'b1010, 32'h44332211, 1'b1, rq);

    // RR: full rotation twice, then lone channel 3
    for (int i = 0; i < 9; i++)
      step(2, 0, 4'b1111, 32'h44332211, 1'b1, rq);
    step(2, 0, 4'b1000, 32'h44332211, 1'b1, rq);
    step(2, 0, 4'b1111, 32'h44332211, 1'b1, rq);
    chk("rr_wrap", int'(rq), 1);

    // backpressure holding 0x22, then no-bubble reload
    step(0, 1, 4'b1111, 32'h44332211, 1'b1, rq);
    step(0, 1, 4'b1111, 32'h44332211, 1'b0, rq);
    for (int i = 0; i < 3; i++)
      step(0, 1, 4'b1111, 32'h44332211, 1'b0, rq);
    step(0, 2, 4'b1111, 32'h44332211, 1'b1, rq);
    #1;
    check_out("no_bubble");

    // random traffic; hold data while valid and stalled
    dat = $urandom;
    vv  = 4'd0;
    rq  = 4'd0;
    for (int t = 0; t < 400; t++) begin
      logic [3:0]  nv;
      logic [31:0] nd;
      nv = 4'($urandom);
      nd = $urandom;
      for (int c = 0; c < N; c++)
        if (vv[c] && !rq[c])
          nd[c*8 +: 8] = dat[c*8 +: 8];
      dat = nd;
      vv  = nv;
      step(int'($urandom_range(0, 3)),
           int'($urandom_range(0, 7)),
           vv, dat, ($urandom_range(0, 9) < 7), rq);
    end
    #1;
    check_out("final");

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
